// File: rtl/axi2mem_trans_arbiter.sv
// axi2mem_trans_arbiter: shares one two-lane command port between a read and a write channel.
// Ports: rd_*/wr_* channel side (pending, per-lane req/add/id/last in, gnt out);
//        cmd_* shared port side (req/add/id/last/we out, gnt in); busy_o high while a burst is locked.
module axi2mem_trans_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int LOCK_BURST = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rd_pending_i,
  input  logic [1:0]              rd_req_i,
  input  logic [2*ADDR_WIDTH-1:0] rd_add_i,
  input  logic [2*ID_WIDTH-1:0]   rd_id_i,
  input  logic [1:0]              rd_last_i,
  output logic [1:0]              rd_gnt_o,
  input  logic                    wr_pending_i,
  input  logic [1:0]              wr_req_i,
  input  logic [2*ADDR_WIDTH-1:0] wr_add_i,
  input  logic [2*ID_WIDTH-1:0]   wr_id_i,
  input  logic [1:0]              wr_last_i,
  output logic [1:0]              wr_gnt_o,
  output logic [1:0]              cmd_req_o,
  output logic [2*ADDR_WIDTH-1:0] cmd_add_o,
  output logic [2*ID_WIDTH-1:0]   cmd_id_o,
  output logic [1:0]              cmd_last_o,
  output logic                    cmd_we_o,
  input  logic [1:0]              cmd_gnt_i,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, RD_LOCK, WR_LOCK} state_t;
  state_t state, state_n;
  logic rr, rr_n;
  logic own_rd, own_wr, hs, last;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
    end
  // Ownership looks only at pending and state, never at req, so req may depend on gnt without a loop.
  always_comb begin
    own_rd     = state == RD_LOCK || (state == IDLE && rd_pending_i && (!wr_pending_i || !rr));
    own_wr     = state == WR_LOCK || (state == IDLE && wr_pending_i && (!rd_pending_i || rr));
    rd_gnt_o   = own_rd ? cmd_gnt_i : 2'b00;
    wr_gnt_o   = own_wr ? cmd_gnt_i : 2'b00;
    cmd_req_o  = own_rd ? rd_req_i & rd_gnt_o : own_wr ? wr_req_i & wr_gnt_o : 2'b00;
    cmd_add_o  = own_rd ? rd_add_i : own_wr ? wr_add_i : '0;
    cmd_id_o   = own_rd ? rd_id_i : own_wr ? wr_id_i : '0;
    cmd_last_o = own_rd ? rd_last_i : own_wr ? wr_last_i : 2'b00;
    cmd_we_o   = own_wr;
    busy_o     = state != IDLE;
    hs         = cmd_gnt_i == 2'b11 && ((own_rd && rd_req_i == 2'b11) || (own_wr && wr_req_i == 2'b11));
    last       = cmd_last_o[0];
    state_n    = state;
    rr_n       = rr;
    if (hs) begin
      if (state == IDLE && !last && LOCK_BURST != 0)
        state_n = own_wr ? WR_LOCK : RD_LOCK;
      else if (state == IDLE || last) begin
        state_n = IDLE;
        rr_n    = own_rd;
      end
    end
  end
endmodule

// File: tb/tb_axi2mem_trans_arbiter.sv
// tb_axi2mem_trans_arbiter: directed scoreboard bench for locked and per-beat arbitration.
module tb_axi2mem_trans_arbiter;
  localparam int AW = 8;
  localparam int IW = 4;
  localparam int W  = 10 + 2*AW + 2*IW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_pending = 1'b0, wr_pending = 1'b0;
  logic [1:0] rd_req = '0, wr_req = '0, rd_last = '0, wr_last = '0, cmd_gnt = '0;
  logic [2*AW-1:0] rd_add = 16'hA1A0, wr_add = 16'hB1B0;
  logic [2*IW-1:0] rd_id = 8'h21, wr_id = 8'h43;
  logic [1:0] o1_rg, o1_wg, o1_cr, o1_cl, o0_rg, o0_wg, o0_cr, o0_cl;
  logic [2*AW-1:0] o1_add, o0_add;
  logic [2*IW-1:0] o1_id, o0_id;
  logic o1_we, o1_busy, o0_we, o0_busy;
  logic [W-1:0] act1, act0;
  int compared = 0;
  int mismatched = 0;
  int queued = 0;
  typedef struct {string name; bit sel; logic [W-1:0] exp;} item_t;
  item_t q[$];
  always #5 clk = ~clk;
  axi2mem_trans_arbiter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LOCK_BURST(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_pending_i(rd_pending), .rd_req_i(rd_req), .rd_add_i(rd_add), .rd_id_i(rd_id), .rd_last_i(rd_last), .rd_gnt_o(o1_rg),
    .wr_pending_i(wr_pending), .wr_req_i(wr_req), .wr_add_i(wr_add), .wr_id_i(wr_id), .wr_last_i(wr_last), .wr_gnt_o(o1_wg),
    .cmd_req_o(o1_cr), .cmd_add_o(o1_add), .cmd_id_o(o1_id), .cmd_last_o(o1_cl), .cmd_we_o(o1_we),
    .cmd_gnt_i(cmd_gnt), .busy_o(o1_busy));
  axi2mem_trans_arbiter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LOCK_BURST(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_pending_i(rd_pending), .rd_req_i(rd_req), .rd_add_i(rd_add), .rd_id_i(rd_id), .rd_last_i(rd_last), .rd_gnt_o(o0_rg),
    .wr_pending_i(wr_pending), .wr_req_i(wr_req), .wr_add_i(wr_add), .wr_id_i(wr_id), .wr_last_i(wr_last), .wr_gnt_o(o0_wg),
    .cmd_req_o(o0_cr), .cmd_add_o(o0_add), .cmd_id_o(o0_id), .cmd_last_o(o0_cl), .cmd_we_o(o0_we),
    .cmd_gnt_i(cmd_gnt), .busy_o(o0_busy));
  assign act1 = {o1_rg, o1_wg, o1_cr, o1_we, o1_busy, o1_cl, o1_add, o1_id};
  assign act0 = {o0_rg, o0_wg, o0_cr, o0_we, o0_busy, o0_cl, o0_add, o0_id};
  function automatic logic [W-1:0] pack(input logic [1:0] rg, wg, cr, input logic we, busy, input int own);
    logic [1:0] l;
    logic [2*AW-1:0] a;
    logic [2*IW-1:0] i;
    l = own == 1 ? rd_last : own == 2 ? wr_last : 2'b00;
    a = own == 1 ? rd_add : own == 2 ? wr_add : '0;
    i = own == 1 ? rd_id : own == 2 ? wr_id : '0;
    return {rg, wg, cr, we, busy, l, a, i};
  endfunction
  task automatic chk(input string n, input bit sel, input logic [1:0] rg, wg, cr, input logic we, busy, input int own);
    item_t it;
    it.name = n;
    it.sel = sel;
    it.exp = pack(rg, wg, cr, we, busy, own);
    q.push_back(it);
    queued++;
  endtask
  task automatic set(input logic rp, wp, input logic [1:0] rq, wq, rl, wl, g);
    @(posedge clk);
    #2;
    rd_pending = rp;
    wr_pending = wp;
    rd_req = rq;
    wr_req = wq;
    rd_last = rl;
    wr_last = wl;
    cmd_gnt = g;
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin : mon
      item_t it;
      logic [W-1:0] act;
      it = q.pop_front();
      act = it.sel ? act1 : act0;
      compared++;
      if (act !== it.exp) begin
        mismatched++;
        $display("FAIL %s (lock=%0d): got %h required %h", it.name, it.sel, act, it.exp);
      end
    end
  initial begin
    set(0, 0, 0, 0, 0, 0, 0); chk("reset", 1, 0, 0, 0, 0, 0, 0);
    #1;
    compared++;
    if (act1 !== pack(0, 0, 0, 0, 0, 0) || act0 !== pack(0, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("FAIL reset_direct: got %h / %h", act1, act0);
    end
    set(0, 0, 3, 0, 0, 0, 3); rst_n = 1'b1;
    chk("no_pend", 1, 0, 0, 0, 0, 0, 0); chk("no_pend", 0, 0, 0, 0, 0, 0, 0);
    set(1, 1, 3, 0, 3, 0, 3); chk("both_rd", 1, 3, 0, 3, 0, 0, 1);
    set(1, 1, 3, 3, 3, 3, 3); chk("both_wr", 1, 0, 3, 3, 1, 0, 2);
    set(1, 1, 1, 3, 3, 3, 3); chk("partial_a", 1, 3, 0, 1, 0, 0, 1);
    set(1, 1, 1, 3, 3, 3, 3); chk("partial_b", 1, 3, 0, 1, 0, 0, 1);
    set(1, 0, 3, 0, 3, 3, 3); chk("single_rd", 1, 3, 0, 3, 0, 0, 1);
    set(1, 1, 3, 3, 3, 0, 3); chk("lk_b1", 1, 0, 3, 3, 1, 0, 2); chk("rr_b1", 0, 0, 3, 3, 1, 0, 2);
    set(1, 1, 3, 3, 3, 0, 3); chk("lk_b2", 1, 0, 3, 3, 1, 1, 2); chk("rr_b2", 0, 3, 0, 3, 0, 0, 1);
    set(1, 1, 3, 3, 3, 0, 3); chk("lk_b3", 1, 0, 3, 3, 1, 1, 2); chk("rr_b3", 0, 0, 3, 3, 1, 0, 2);
    set(1, 1, 3, 3, 3, 3, 3); chk("lk_b4", 1, 0, 3, 3, 1, 1, 2); chk("rr_b4", 0, 3, 0, 3, 0, 0, 1);
    set(1, 1, 3, 3, 3, 3, 3); chk("lk_rd", 1, 3, 0, 3, 0, 0, 1); chk("rr_b5", 0, 0, 3, 3, 1, 0, 2);
    set(0, 1, 0, 3, 0, 0, 3); chk("wl_b1", 1, 0, 3, 3, 1, 0, 2);
    for (int k = 0; k < 3; k++) begin
      set(1, 1, 3, 3, 0, 0, 1); chk("wl_part", 1, 0, 1, 1, 1, 1, 2);
    end
    set(1, 0, 3, 0, 0, 0, 3); chk("wl_drop", 1, 0, 3, 0, 1, 1, 2);
    set(0, 1, 0, 3, 0, 3, 3); chk("wl_end", 1, 0, 3, 3, 1, 1, 2);
    set(1, 0, 3, 0, 0, 0, 3); chk("rl_b1", 1, 3, 0, 3, 0, 0, 1);
    set(1, 0, 3, 0, 0, 0, 3); chk("rl_b2", 1, 3, 0, 3, 0, 1, 1);
    set(0, 0, 0, 0, 0, 0, 3); rst_n = 1'b0; chk("rst_mid", 1, 0, 0, 0, 0, 0, 0);
    set(0, 1, 0, 3, 0, 3, 3); rst_n = 1'b1; chk("post_wr", 1, 0, 3, 3, 1, 0, 2);
    set(0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0; chk("rst2", 1, 0, 0, 0, 0, 0, 0);
    set(1, 1, 3, 3, 3, 3, 3); rst_n = 1'b1; chk("first_rd", 1, 3, 0, 3, 0, 0, 1);
    set(0, 0, 0, 0, 0, 0, 0);
    fork
      wait (q.size() == 0);
      repeat (20) @(posedge clk);
    join_any
    disable fork;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL timeout: %0d checks never evaluated", q.size());
    end
    @(negedge clk);
    #1;
    if (compared != queued + 1) begin
      mismatched++;
      $display("FAIL count: compared %0d, queued %0d", compared, queued);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi2mem_trans_arbiter.md
AXI2MEM_TRANS_ARBITER -- requirements
Module: axi2mem_trans_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: width of each lane address.
REQ-002 The block SHALL have parameter ID_WIDTH, default 6: width of each lane transaction id.
REQ-003 The block SHALL have parameter LOCK_BURST, default 1: 1 = a granted burst holds the port until its last beat; 0 = round-robin per beat.
REQ-004 The block SHALL have these ports (clock and reset first):
- clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
- rd_pending_i  in  1  read channel has a beat ready; independent of rd_gnt_o.
- rd_req_i  in  2  read per-lane request; may depend combinationally on rd_gnt_o.
- rd_add_i  in  2xADDR_WIDTH  lane addresses.
- rd_id_i  in  2xID_WIDTH  lane ids.
- rd_last_i  in  2  lane last-beat flags.
- rd_gnt_o  out  2  grant to the read channel.
- wr_pending_i, wr_req_i, wr_add_i, wr_id_i, wr_last_i, wr_gnt_o: write-channel equivalents, same widths.
- cmd_req_o  out  2  shared port request.
- cmd_add_o  out  2xADDR_WIDTH  shared port address.
- cmd_id_o  out  2xID_WIDTH  shared port id.
- cmd_last_o  out  2  shared port last flag.
- cmd_we_o  out  1  1 = write beat, 0 = read beat.
- cmd_gnt_i  in  2  shared port lane availability.
- busy_o  out  1  high when state is not IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, RD_LOCK and WR_LOCK; RD_LOCK and WR_LOCK are unreachable when LOCK_BURST=0.
REQ-006 The selected owner SHALL be computed only from state, the rr pointer, rd_pending_i and wr_pending_i, and never from *_req_i, so that no combinational loop exists.
REQ-007 In IDLE, owner selection SHALL be:
- only one channel pending: that channel;
- both pending: the channel the rr pointer designates;
- none pending: no owner.
REQ-008 In RD_LOCK the owner SHALL be read, and in WR_LOCK the owner SHALL be write, regardless of pending inputs.
REQ-009 The owner's *_gnt_o SHALL equal cmd_gnt_i, and the non-owner's *_gnt_o SHALL be 2'b00.
REQ-010 cmd_req_o SHALL equal the owner's req masked by the owner's gnt_o, and SHALL be 2'b00 with no owner.
REQ-011 cmd_add_o, cmd_id_o and cmd_last_o SHALL mux from the owner; with no owner they SHALL be zero.
REQ-012 cmd_we_o SHALL be 1 exactly when the owner is the write channel.
REQ-013 A handshake SHALL occur when the owner's req==2'b11 and cmd_gnt_i==2'b11 in the same cycle; partial requests (01/10) SHALL be passed through but SHALL cause no state or pointer change.
REQ-014 On a handshake in IDLE with last[0]==0 and LOCK_BURST=1, the next state SHALL be the owner's LOCK state.
REQ-015 On a handshake in IDLE with last[0]==1, or with LOCK_BURST=0, the state SHALL remain IDLE and the rr pointer SHALL move to the other channel.
REQ-016 On a handshake in a LOCK state with last[0]==1, the next state SHALL be IDLE and the rr pointer SHALL move to the other channel.
REQ-017 On a handshake in a LOCK state with last[0]==0, the state SHALL be held.
REQ-018 In a LOCK state, the owner dropping pending or req SHALL hold the state with no timeout.
REQ-019 Grant latency SHALL be zero cycles: a pending channel sees gnt in the same cycle it is selected.
REQ-020 There SHALL be no bubble between back-to-back single-beat transactions.
REQ-021 The rr pointer SHALL be 1 bit (0 = read first, 1 = write first) and SHALL change only per REQ-015 and REQ-016.
REQ-022 No internal storage of address, id or data SHALL exist; the block SHALL be a pure routing and sequencing element apart from the state and pointer registers.

Reset
REQ-023 Asynchronous assertion of rst_ni SHALL force state=IDLE and rr pointer=0 immediately, including mid-burst.
REQ-024 During reset, all outputs SHALL follow REQ-009..REQ-012 with no owner unless pending inputs are high: all gnt/req zero, cmd_we_o=0, busy_o=0.
REQ-025 After reset release, the first pending contest SHALL be won by the read channel.

Verification
REQ-026 Reset, both pending, cmd_gnt_i=11, rd_req=11, rd_last=11 -> rd_gnt_o=11, wr_gnt_o=00, cmd_we_o=0. Next cycle, wr_req=11 -> wr_gnt_o=11, cmd_we_o=1.
REQ-027 LOCK_BURST=1, write 4-beat burst (last on beat 4), rd_pending_i held high -> wr_gnt_o=11 for all 4 handshakes, rd_gnt_o=00 throughout, busy_o=1 from cycle 2 to 4, read granted in cycle 5.
REQ-028 LOCK_BURST=0, same stimulus as REQ-027 -> grants alternate wr,rd,wr,rd per handshake cycle.
REQ-029 In WR_LOCK, cmd_gnt_i=01 for 3 cycles -> cmd_req_o=01, no state or pointer change; on return to 11 the burst resumes.
REQ-030 Assert rst_ni low during RD_LOCK beat 2 -> busy_o=0 at once, and after release wr_pending alone -> wr_gnt_o=11 in the first cycle.
REQ-031 No pending, cmd_gnt_i=11 -> all *_gnt_o=00, cmd_req_o=00, cmd_add_o=0.
